// File: rtl/fifo_rd_stream_bridge_if.sv
// Bundles the FIFO read port and the AXI-Stream master side of the bridge.
// No logic; pure signal grouping.
// The master modport is the bridge view; slave is the FIFO/sink view.
interface fifo_rd_stream_bridge_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_rst_busy;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  fifo_dout, fifo_empty, fifo_rd_rst_busy, m_axis_tready,
        output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_rd_rst_busy, m_axis_tready,
        input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/fifo_rd_stream_bridge.sv
// Drains a fixed-latency FIFO read port into an AXI-Stream master with per-packet tlast.
// Latency: READ_LATENCY+1 cycles from first rd_en to first tvalid, then one word per cycle.
// Backpressure: reads are issued only while skid entries plus in-flight reads leave room, so no word is lost.
module fifo_rd_stream_bridge #(
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1,
    parameter int SKID_DEPTH   = 4,
    parameter int LEN_WIDTH    = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    fifo_rd_stream_bridge_if.master bus,
    input  logic                   pkt_start,
    input  logic [LEN_WIDTH-1:0]   pkt_len_words,
    output logic                   busy,
    output logic [LEN_WIDTH-1:0]   words_sent
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   rd_issued_q, rd_issued_d;
    logic [LEN_WIDTH-1:0]   words_sent_q, words_sent_d;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [DATA_WIDTH-1:0]  mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       inflight;
    logic [LEN_WIDTH-1:0]   len_last;
    logic                   room, rd_en, push, pop, tvalid;

    assign len_last = len_q - LEN_WIDTH'(1);
    assign room     = ({1'b0, count_q} + {1'b0, inflight}) < (CNT_W + 1)'(SKID_DEPTH);
    assign rd_en    = (state_q == RUN) & ~bus.fifo_empty & ~bus.fifo_rd_rst_busy
                      & (rd_issued_q < len_q) & room;
    // The oldest pipe stage marks the cycle in which fifo_dout carries a requested word.
    assign push     = pipe_q[READ_LATENCY-1];
    assign tvalid   = (count_q != '0);
    assign pop      = tvalid & bus.m_axis_tready;

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = mem_q[rd_ptr_q];
    assign bus.m_axis_tlast  = tvalid & (words_sent_q == len_last);
    assign busy              = (state_q != IDLE);
    assign words_sent        = words_sent_q;

    // Count reads issued but not yet captured into the skid buffer.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
    end

    // Packet sequencing: accept a start, issue len reads, then wait for the last beat.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_issued_d  = rd_issued_q;
        words_sent_d = words_sent_q;
        if (rd_en) begin
            rd_issued_d = rd_issued_q + LEN_WIDTH'(1);
        end
        if (pop) begin
            words_sent_d = words_sent_q + LEN_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (pkt_start && (pkt_len_words != '0)) begin
                    len_d        = pkt_len_words;
                    rd_issued_d  = '0;
                    words_sent_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (rd_issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (words_sent_q == len_last)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; an in-progress packet is simply dropped on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rd_issued_q  <= '0;
            words_sent_q <= '0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_issued_q  <= rd_issued_d;
            words_sent_q <= words_sent_d;
            pipe_q       <= (pipe_q << 1) | READ_LATENCY'(rd_en);
        end
    end

    // Skid ring buffer: push at tail when a read lands, pop head on handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.fifo_dout;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream_bridge.sv
`timescale 1ns/1ps
module tb_fifo_rd_stream_bridge;
    localparam int DW = 16;
    localparam int LW = 12;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          pkt_start = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          tready = 1'b0;
    logic          force_empty = 1'b0;
    logic          rst_busy = 1'b0;

    // Shared FIFO contents; each instance keeps its own read pointer.
    logic [DW-1:0] fmem [1024];
    int            wr_cnt = 0;
    logic [DW-1:0] wval = '0;

    logic          busy [2];
    logic [LW-1:0] ws [2];
    logic [DW:0]   exp_q0 [$];
    logic [DW:0]   exp_q1 [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int inst, longint act, longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s RL=%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, inst + 1, act, expv, cyc);
        end
    endfunction

    function automatic void sb_pop(int inst, logic [DW-1:0] d, logic l);
        logic [DW:0] e;
        int sz;
        sz = (inst == 0) ? exp_q0.size() : exp_q1.size();
        chk("beat_expected", inst, (sz > 0), 1);
        if (sz > 0) begin
            if (inst == 0) e = exp_q0.pop_front();
            else           e = exp_q1.pop_front();
            chk("tdata", inst, d, e[DW-1:0]);
            chk("tlast", inst, l, e[DW]);
        end
    endfunction

    fifo_rd_stream_bridge_if #(.DATA_WIDTH(DW)) bus [2] ();

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int RL = gi + 1;
        int            rd_cnt = 0;
        logic [DW-1:0] dst [RL];
        int  outst = 0;
        int  first_rd = -1, last_rd = -1, first_vld = -1, first_hs = -1, last_hs = -1;
        bit  fall_pend = 0;
        bit  prev_stall = 0;
        logic [DW-1:0] prev_dat = '0;
        logic          prev_last = 1'b0;

        assign bus[gi].fifo_empty       = force_empty | (rd_cnt == wr_cnt);
        assign bus[gi].fifo_rd_rst_busy = rst_busy;
        assign bus[gi].m_axis_tready    = tready;
        assign bus[gi].fifo_dout        = dst[RL-1];

        fifo_rd_stream_bridge #(
            .DATA_WIDTH(DW), .READ_LATENCY(RL), .SKID_DEPTH(SD), .LEN_WIDTH(LW)
        ) dut (
            .clk(clk), .rstn(rstn), .bus(bus[gi]),
            .pkt_start(pkt_start), .pkt_len_words(pkt_len),
            .busy(busy[gi]), .words_sent(ws[gi])
        );

        // FIFO read-port model with RL cycles of dout latency; reset flushes it.
        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_cnt <= wr_cnt;
                for (int k = 0; k < RL; k++) dst[k] <= '0;
            end else begin
                dst[0] <= bus[gi].fifo_rd_en ? fmem[rd_cnt % 1024] : 16'hDEAD;
                for (int k = 1; k < RL; k++) dst[k] <= dst[k-1];
                if (bus[gi].fifo_rd_en) rd_cnt <= rd_cnt + 1;
            end
        end

        // Protocol monitor and scoreboard consumer, sampled mid-cycle.
        always @(negedge clk) begin
            if (!rstn) begin
                outst = 0;
                fall_pend = 0;
                prev_stall = 0;
            end else begin
                if (pkt_start && !busy[gi] && pkt_len != '0) begin
                    first_rd = -1; last_rd = -1; first_vld = -1; first_hs = -1; last_hs = -1;
                end
                if (fall_pend) begin
                    chk("busy_fall", gi, busy[gi], 0);
                    fall_pend = 0;
                end
                if (prev_stall)
                    chk("hold", gi, {bus[gi].m_axis_tvalid, bus[gi].m_axis_tlast, bus[gi].m_axis_tdata},
                        {1'b1, prev_last, prev_dat});
                if (bus[gi].fifo_rd_en) begin
                    chk("rd_gate", gi, bus[gi].fifo_empty | rst_busy, 0);
                    chk("rd_room", gi, (outst < SD), 1);
                    chk("rd_busy", gi, busy[gi], 1);
                    if (first_rd < 0) first_rd = cyc;
                    last_rd = cyc;
                end
                if (bus[gi].m_axis_tvalid && first_vld < 0 && first_rd >= 0) begin
                    first_vld = cyc;
                    chk("first_latency", gi, first_vld - first_rd, RL + 1);
                end
                if (bus[gi].m_axis_tvalid && tready) begin
                    sb_pop(gi, bus[gi].m_axis_tdata, bus[gi].m_axis_tlast);
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    if (bus[gi].m_axis_tlast) begin
                        chk("busy_at_last", gi, busy[gi], 1);
                        fall_pend = 1;
                    end
                end
                outst = outst + int'(bus[gi].fifo_rd_en) - int'(bus[gi].m_axis_tvalid & tready);
                prev_stall = bus[gi].m_axis_tvalid & ~tready;
                prev_dat   = bus[gi].m_axis_tdata;
                prev_last  = bus[gi].m_axis_tlast;
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rd_en"},  0, bus[0].fifo_rd_en, 0);
        chk({tag, "_tvalid"}, 0, bus[0].m_axis_tvalid, 0);
        chk({tag, "_tlast"},  0, bus[0].m_axis_tlast, 0);
        chk({tag, "_tdata"},  0, bus[0].m_axis_tdata, 0);
        chk({tag, "_busy"},   0, busy[0], 0);
        chk({tag, "_ws"},     0, ws[0], 0);
        chk({tag, "_rd_en"},  1, bus[1].fifo_rd_en, 0);
        chk({tag, "_tvalid"}, 1, bus[1].m_axis_tvalid, 0);
        chk({tag, "_tlast"},  1, bus[1].m_axis_tlast, 0);
        chk({tag, "_tdata"},  1, bus[1].m_axis_tdata, 0);
        chk({tag, "_busy"},   1, busy[1], 0);
        chk({tag, "_ws"},     1, ws[1], 0);
    endtask

    // Put len words into the FIFO and their expected beats into both scoreboards.
    task automatic load_pkt(int len);
        for (int j = 0; j < len; j++) begin
            fmem[wr_cnt % 1024] = wval;
            exp_q0.push_back({(j == len - 1), wval});
            exp_q1.push_back({(j == len - 1), wval});
            wr_cnt = wr_cnt + 1;
            wval = wval + 1'b1;
        end
    endtask

    task automatic start_pkt(int len);
        pkt_len = LW'(len);
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
    endtask

    function automatic logic rdy_of(int mode, int k);
        case (mode)
            1:       return logic'(k % 2 == 0);
            2:       return logic'($urandom_range(0, 1));
            3:       return logic'(k % 3 == 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_until_idle(int rmode, int smode, int budget);
        bit done = 0;
        for (int k = 0; k < budget; k++) begin
            tready      = rdy_of(rmode, k);
            force_empty = (smode == 1) && (k >= 2) && (k <= 4);
            rst_busy    = (smode == 2) && (k >= 2) && (k <= 5);
            @(posedge clk); #1;
            if (!busy[0] && !busy[1]) begin
                done = 1;
                break;
            end
        end
        chk("idle_within_budget", 0, done, 1);
        tready = 1'b0;
        force_empty = 1'b0;
        rst_busy = 1'b0;
    endtask

    task automatic check_done(logic [LW-1:0] exp_ws);
        chk("words_sent", 0, ws[0], exp_ws);
        chk("words_sent", 1, ws[1], exp_ws);
        chk("sb_drained", 0, exp_q0.size(), 0);
        chk("sb_drained", 1, exp_q1.size(), 0);
        chk("fifo_drained", 0, g[0].rd_cnt, wr_cnt);
        chk("fifo_drained", 1, g[1].rd_cnt, wr_cnt);
    endtask

    typedef struct {
        int len;
        int rmode;      // 0 always ready, 1 toggle, 2 random, 3 one in three
        int smode;      // 0 none, 1 FIFO empty for 3 cycles, 2 read reset busy for 4 cycles
        int exp_ws;
        bit full_rate;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{8, 0, 0, 8, 1};
        vt[1] = '{16, 1, 0, 16, 0};
        vt[2] = '{6, 0, 1, 6, 0};
        vt[3] = '{0, 0, 0, 6, 0};
        vt[4] = '{5, 2, 2, 5, 0};
        vt[5] = '{1, 0, 0, 1, 1};
        vt[6] = '{3, 3, 0, 3, 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            load_pkt(vt[v].len);
            start_pkt(vt[v].len);
            chk("busy_after_start", 0, busy[0], (vt[v].len != 0));
            chk("busy_after_start", 1, busy[1], (vt[v].len != 0));
            chk("ws_after_start", 0, ws[0], (vt[v].len != 0) ? 0 : vt[v].exp_ws);
            run_until_idle(vt[v].rmode, vt[v].smode, 400);
            repeat (3) @(posedge clk);
            #1;
            check_done(LW'(vt[v].exp_ws));
            if (vt[v].full_rate) begin
                chk("rd_en_span", 0, g[0].last_rd - g[0].first_rd, vt[v].len - 1);
                chk("rd_en_span", 1, g[1].last_rd - g[1].first_rd, vt[v].len - 1);
                chk("beat_span", 0, g[0].last_hs - g[0].first_hs, vt[v].len - 1);
                chk("beat_span", 1, g[1].last_hs - g[1].first_hs, vt[v].len - 1);
            end
        end

        // A start pulse while busy must not change the packet length.
        load_pkt(4);
        start_pkt(4);
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_pkt(9);
        run_until_idle(0, 0, 100);
        repeat (3) @(posedge clk);
        #1;
        check_done(LW'(4));

        // Reset in the middle of a packet, then a fresh 2-word packet.
        load_pkt(6);
        start_pkt(6);
        tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_tvalid", 0, bus[0].m_axis_tvalid, 1);
        chk("pre_reset_tvalid", 1, bus[1].m_axis_tvalid, 1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        load_pkt(2);
        start_pkt(2);
        run_until_idle(0, 0, 100);
        repeat (3) @(posedge clk);
        #1;
        check_done(LW'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_rd_stream_bridge.md
Name: fifo_rd_stream_bridge

Overview:
Read-side companion for the asynchronous FIFO used in tx_intf. It drains the FIFO's read port (rd_en/dout/empty, fixed read latency) in the FIFO's read-clock domain and presents the words as an AXI-Stream master with per-packet tlast. An internal skid buffer absorbs the FIFO read latency, so downstream back-pressure never loses or duplicates a word.

Parameters:
DATA_WIDTH, 64, width of FIFO dout and m_axis_tdata
READ_LATENCY, 1, FIFO dout latency after rd_en in cycles; legal values 1 or 2
SKID_DEPTH, 4, internal buffer entries; power of 2, >= READ_LATENCY+2
LEN_WIDTH, 12, width of packet length and word counters

Ports:
clk  in  1  single clock, rising edge; connects to the FIFO read clock
rstn  in  1  reset; asynchronous assert, active-low
fifo_dout  in  DATA_WIDTH  FIFO read data
fifo_empty  in  1  FIFO empty flag
fifo_rd_rst_busy  in  1  FIFO read-side reset in progress
fifo_rd_en  out  1  FIFO read enable
pkt_start  in  1  one-cycle pulse that starts a packet
pkt_len_words  in  LEN_WIDTH  packet length in words; sampled on pkt_start
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  high on the final word of a packet
busy  out  1  high from packet acceptance until the last word is transferred
words_sent  out  LEN_WIDTH  count of handshakes in the current packet

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; fifo_rd_en, m_axis_tvalid, m_axis_tlast, busy = 0; m_axis_tdata=0; words_sent=0; skid buffer, in-flight pipe and counters are cleared. On deassertion, the block resumes in IDLE. An in-progress packet is abandoned without recovery.
- States:
  - IDLE: pkt_start with pkt_len_words != 0 latches len, clears rd_issued and words_sent, sets busy=1, then moves to RUN. pkt_start with len=0 is ignored and the block stays in IDLE.
  - RUN: issues reads until rd_issued == len, then moves to DRAIN.
  - DRAIN: waits for the handshake of word len-1, then moves to IDLE with busy=0 on the following cycle.
  - pkt_start outside IDLE is ignored.
- fifo_rd_en (registered-free combinational) = (state==RUN) & !fifo_empty & !fifo_rd_rst_busy & (rd_issued < len) & (skid_count + inflight < SKID_DEPTH).
  - inflight = number of reads issued whose data has not yet been captured, range 0..READ_LATENCY.
- Read latency handling: a READ_LATENCY-deep valid shift register tracks reads. When its output bit is set, fifo_dout is written into the skid buffer tail. The skid buffer never overflows, by construction.
- Stream output:
  - m_axis_tvalid = (skid_count != 0); m_axis_tdata = skid head.
  - A handshake (tvalid & tready) pops the head and increments words_sent.
  - m_axis_tlast = tvalid & (words_sent == len-1).
  - tdata and tlast stay stable while tvalid & !tready.
- Simultaneous push and pop in the same cycle: skid_count is unchanged and ordering is preserved (FIFO order).
- Skid pointers wrap modulo SKID_DEPTH.
- fifo_rd_rst_busy or fifo_empty asserted mid-packet: reads stall, already in-flight words are still captured, and output continues from the buffer.
- Throughput: with tready held at 1 and the FIFO non-empty, one word per cycle is sustained after an initial latency of READ_LATENCY+1 cycles from the first rd_en to the first tvalid.
- words_sent holds its final value in IDLE until the next accepted pkt_start.

Test Plan:
- Throughput: READ_LATENCY=1, FIFO preloaded with 8 words 0x00..0x07, pkt_len=8, tready=1 -> rd_en high for 8 consecutive cycles; tdata 0..7 on consecutive cycles; tlast only with 0x07; busy falls 1 cycle after the last beat; words_sent=8.
- Back-pressure: READ_LATENCY=2, 16 words, tready toggled 1/0 each cycle -> exactly 16 handshakes, in order, no duplicates; skid_count never exceeds 4; rd_en deasserts whenever skid_count+inflight=4.
- Starved FIFO: fifo_empty pulses high for 3 cycles in the middle of a 6-word packet -> rd_en low during those cycles; stream pauses, then resumes in order; tlast on word 5.
- Length rules: pkt_start with len=0 -> busy stays 0 and no rd_en. A second pkt_start while busy -> ignored; the current packet completes with its original length.
- Stall then reset: fifo_rd_rst_busy=1 for 4 cycles mid-packet -> no rd_en, in-flight words still delivered. Then rstn=0 mid-packet -> all outputs 0 immediately; a new 2-word packet after release completes correctly.
